cordic_vectoring_four_loop: RTL and testbench
=============================================

# cordic_vectoring_four_loop

Iterative CORDIC in vectoring mode: takes a Cartesian vector (x, y) and returns its angle atan(y/x). With the magnitude option compiled in, it also returns the gain-compensated magnitude. It is the inverse companion of the rotation-mode cosine unit and shares that unit's 22-bit fixed-point format and arctangent table. It performs 16 micro-rotations, 4 per clock, and sits behind the same clk_en/done start-finish handshake.

## Interface
- ITERS, 16, total micro-rotations; must be a multiple of PER_CYCLE.
- PER_CYCLE, 4, micro-rotations unrolled per clock.
- WIDTH, 22, datapath width; signed Q2.20 (1 sign bit, 1 integer bit, 20 fraction bits).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- clk_en  in  1  start strobe; sampled only in IDLE.
- x_in  in  22  signed Q2.20 x component.
- y_in  in  22  signed Q2.20 y component.
- angle_out  out  22  signed Q2.20 radians, range [-pi/2, +pi/2].
- mag_out  out  22  Q2.20 magnitude; present only with CORDIC_VEC_MAG_EN.
- busy  out  1  high from operand capture until the cycle done is asserted.
- done  out  1  one-cycle pulse; result valid.
- range_err  out  1  valid with done; high when x_in < 0.

## Operation
States and transitions:
- IDLE: on clk_en, capture x_in and y_in, set z = 0, set i = 0, then go to ITER.
- ITER: perform PER_CYCLE micro-rotations per clock. Go to FINISH when i reaches ITERS.
- FINISH: register the outputs, pulse done, then return to IDLE.
- With CORDIC_VEC_MAG_EN, a SCALE state sits between ITER and FINISH.

Micro-rotation i, with d = y[21]:
- d = 0 (y ≥ 0): x += y>>>i; y -= x_old>>>i; z += e_i.
- d = 1 (y < 0): x -= y>>>i; y += x_old>>>i; z -= e_i.
- Both shifts use the pre-update x and y; shifts are arithmetic.

Arctangent table, e_i = atan(2^-i) in Q2.20, for i = 0..15:
- C90FD, 76B19, 3EB6E, 1FD5B, 0FFAA, 07FF5, 03FFE, 01FFF
- 00FFF, 007FF, 003FF, 001FF, 000FF, 0007F, 0003F, 0001F

Arithmetic and input rules:
- Arithmetic wraps at 22 bits with no saturation.
- Caller guarantees |x_in| and |y_in| ≤ 0.75 (0x0C0000). Under that bound the internal x growth (×1.6468) stays below 2.0.

Boundary conditions:
- x_in < 0: iterations still run. angle_out = 0, mag_out = 0, range_err = 1, with done at normal latency.
- x_in = 0 and y_in = 0: angle_out = 0, mag_out = 0, range_err = 0.
- clk_en while busy: ignored; no queuing.
- clk_en in the FINISH cycle: ignored. A new start is accepted from the cycle after done.
- Operands are sampled only at capture; later changes to x_in/y_in have no effect.
- Outputs hold their last result until the next done.

## Timing
- Reset (synchronous, any state): state = IDLE. angle_out, mag_out, done, busy and range_err all = 0. An in-flight operation is discarded with no done.
- clk_en sampled high at edge N (IDLE):
  - busy = 1 after edge N.
  - ITER runs on edges N+1..N+4.
  - done = 1 after edge N+5, for exactly one cycle; busy falls at the same edge.
- With CORDIC_VEC_MAG_EN, SCALE occupies edge N+5 and done rises after edge N+6.
- Throughput: one operation per 6 cycles (7 with CORDIC_VEC_MAG_EN).

## Configuration
- CORDIC_VEC_MAG_EN defined:
  - mag_out port exists.
  - SCALE state multiplies the final x by K = 0x09B74E (0.60725) as a 22×22 signed product, keeping bits [41:20], truncated.
  - Adds one cycle of latency.
- Undefined:
  - No mag_out port, no multiplier, no SCALE state.
  - Latency is 5 cycles from capture to done.

## Structure
- Shared package cordic_pkg:
  - WIDTH, frac-bits constant (20), atan table function/array, K constant.
  - State enum typedef.
  - The rotation-mode unit uses the same package.
- Sub-module cordic_vec_stage: combinational single micro-rotation. Inputs x, y, z, shift index i, e_i; outputs updated x, y, z. Instantiated PER_CYCLE times in a chain.
- Top level holds the FSM, the i counter, operand capture, output registers and the optional scale stage.

## Test plan
- x=0x080000, y=0, pulse clk_en → done after edge N+5. angle_out within ±0x40 of 0; range_err = 0; with MAG_EN, mag_out within ±0x40 of 0x080000.
- x=0x080000, y=0x080000 → angle_out = 0x0C90FD ±0x40; with MAG_EN, mag_out = 0x0B504F (0.7071) ±0x40.
- x=0x080000, y=0x380000 (−0.5) → angle_out = 0x336F03 (−pi/4) ±0x40.
- x=0, y=0x080000 → angle_out = 0x1921FB (pi/2) ±0x40.
- x=0x380000 (negative), y=0x010000 → done at normal latency with range_err = 1, angle_out = 0.
- Control corner cases, in one run:
  - Reset asserted at N+2 → no done, all outputs 0.
  - Restart, then clk_en pulsed at N+1..N+5 → only one done.
  - clk_en one cycle after done → accepted, correct second result.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared CORDIC fixed-point constants, state encoding and
//               arctangent table (Q2.20) for the rotation and vectoring units.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int c_WIDTH     = 22;
    localparam int c_FRAC_BITS = 20;
    localparam int c_ITERS     = 16;

    // Reciprocal CORDIC gain 0.60725 in Q2.20
    localparam logic [c_WIDTH-1:0] c_K_GAIN = 22'h09B74E;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_SCALE  = 2'd2,
        S_FINISH = 2'd3
    } cordic_state_t;

    // e_i = atan(2^-i), truncated to Q2.20
    function automatic logic [c_WIDTH-1:0] atan_lut(input logic [3:0] idx);
        logic [c_WIDTH-1:0] v;
        case (idx)
            4'd0:    v = 22'h0C90FD;
            4'd1:    v = 22'h076B19;
            4'd2:    v = 22'h03EB6E;
            4'd3:    v = 22'h01FD5B;
            4'd4:    v = 22'h00FFAA;
            4'd5:    v = 22'h007FF5;
            4'd6:    v = 22'h003FFE;
            4'd7:    v = 22'h001FFF;
            4'd8:    v = 22'h000FFF;
            4'd9:    v = 22'h0007FF;
            4'd10:   v = 22'h0003FF;
            4'd11:   v = 22'h0001FF;
            4'd12:   v = 22'h0000FF;
            4'd13:   v = 22'h00007F;
            4'd14:   v = 22'h00003F;
            default: v = 22'h00001F;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_vec_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vec_stage
// Description : One combinational vectoring-mode micro-rotation; drives y
//               toward zero and accumulates the applied angle in z.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_stage #(
    parameter int WIDTH   = 22,
    parameter int SHIFT_W = 4
) (
    input  logic signed [WIDTH-1:0]   x_in,
    input  logic signed [WIDTH-1:0]   y_in,
    input  logic signed [WIDTH-1:0]   z_in,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic signed [WIDTH-1:0]   e_i,
    output logic signed [WIDTH-1:0]   x_out,
    output logic signed [WIDTH-1:0]   y_out,
    output logic signed [WIDTH-1:0]   z_out
);

    logic signed [WIDTH-1:0] w_x_sh;
    logic signed [WIDTH-1:0] w_y_sh;
    logic                    w_neg;

    assign w_x_sh = x_in >>> shift;
    assign w_y_sh = y_in >>> shift;
    assign w_neg  = y_in[WIDTH-1];

    assign x_out = w_neg ? (x_in - w_y_sh) : (x_in + w_y_sh);
    assign y_out = w_neg ? (y_in + w_x_sh) : (y_in - w_x_sh);
    assign z_out = w_neg ? (z_in - e_i)    : (z_in + e_i);

endmodule
`default_nettype wire

// File: rtl/cordic_vectoring_four_loop.sv
`default_nettype none
// ============================================================================
// Module      : cordic_vectoring_four_loop
// Description : Iterative vectoring CORDIC, PER_CYCLE micro-rotations per
//               clock; returns atan(y/x). Define CORDIC_VEC_MAG_EN to add the
//               gain-compensated magnitude output and its SCALE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_vectoring_four_loop
    import cordic_pkg::*;
#(
    parameter int ITERS     = 16,
    parameter int PER_CYCLE = 4,
    parameter int WIDTH     = c_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic signed [WIDTH-1:0] angle_out,
`ifdef CORDIC_VEC_MAG_EN
    output logic signed [WIDTH-1:0] mag_out,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    range_err
);

    localparam int SHIFT_W = $clog2(ITERS);
    localparam int CNT_W   = $clog2(ITERS + 1);

    cordic_state_t r_state;
    cordic_state_t w_state_next;

    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic        [CNT_W-1:0] r_iter;
    logic                    r_neg;
    logic                    r_zero;
    logic                    w_iter_last;

    logic signed [WIDTH-1:0] w_x [0:PER_CYCLE];
    logic signed [WIDTH-1:0] w_y [0:PER_CYCLE];
    logic signed [WIDTH-1:0] w_z [0:PER_CYCLE];

    assign w_x[0] = r_x;
    assign w_y[0] = r_y;
    assign w_z[0] = r_z;

    generate
        for (genvar k = 0; k < PER_CYCLE; k++) begin : g_stage
            logic [SHIFT_W-1:0]      w_shift;
            logic signed [WIDTH-1:0] w_e;

            assign w_shift = r_iter[SHIFT_W-1:0] + SHIFT_W'(k);
            assign w_e     = atan_lut(w_shift);

            cordic_vec_stage #(
                .WIDTH   (WIDTH),
                .SHIFT_W (SHIFT_W)
            ) u_stage (
                .x_in  (w_x[k]),
                .y_in  (w_y[k]),
                .z_in  (w_z[k]),
                .shift (w_shift),
                .e_i   (w_e),
                .x_out (w_x[k+1]),
                .y_out (w_y[k+1]),
                .z_out (w_z[k+1])
            );
        end
    endgenerate

    assign w_iter_last = (r_iter == CNT_W'(ITERS - PER_CYCLE));

`ifdef CORDIC_VEC_MAG_EN
    logic signed [WIDTH-1:0] w_scaled;

    // Full 44-bit signed product, keep bits [41:20] (truncated Q2.20)
    assign w_scaled = WIDTH'(($signed({{WIDTH{r_x[WIDTH-1]}}, r_x}) *
                              $signed({{WIDTH{1'b0}}, c_K_GAIN})) >>> c_FRAC_BITS);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (clk_en) begin
                    w_state_next = S_ITER;
                end
            end
            S_ITER: begin
                if (w_iter_last) begin
`ifdef CORDIC_VEC_MAG_EN
                    w_state_next = S_SCALE;
`else
                    w_state_next = S_FINISH;
`endif
                end
            end
            S_SCALE:  w_state_next = S_FINISH;
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_iter    <= '0;
            r_neg     <= 1'b0;
            r_zero    <= 1'b0;
            angle_out <= '0;
`ifdef CORDIC_VEC_MAG_EN
            mag_out   <= '0;
`endif
            busy      <= 1'b0;
            done      <= 1'b0;
            range_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clk_en) begin
                        r_x    <= x_in;
                        r_y    <= y_in;
                        r_z    <= '0;
                        r_iter <= '0;
                        r_neg  <= x_in[WIDTH-1];
                        r_zero <= (x_in == '0) && (y_in == '0);
                        busy   <= 1'b1;
                    end
                end
                S_ITER: begin
                    r_x    <= w_x[PER_CYCLE];
                    r_y    <= w_y[PER_CYCLE];
                    r_z    <= w_z[PER_CYCLE];
                    r_iter <= r_iter + CNT_W'(PER_CYCLE);
                end
                S_SCALE: begin
`ifdef CORDIC_VEC_MAG_EN
                    r_x <= w_scaled;
`endif
                end
                S_FINISH: begin
                    // Negative x and the origin report zero rather than the
                    // meaningless accumulated angle
                    angle_out <= (r_neg || r_zero) ? '0 : r_z;
`ifdef CORDIC_VEC_MAG_EN
                    mag_out   <= (r_neg || r_zero) ? '0 : r_x;
`endif
                    range_err <= r_neg;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring_four_loop.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_vectoring_four_loop
// Description : Self-checking bench for the vectoring CORDIC against a
//               real-arithmetic atan2/hypot reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vectoring_four_loop;

`ifdef CORDIC_VEC_MAG_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif
    localparam int TOL_DIR = 'h40;
    localparam int TOL_RND = 'h60;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [21:0] x_in;
    logic [21:0] y_in;
    logic [21:0] angle_out;
`ifdef CORDIC_VEC_MAG_EN
    logic [21:0] mag_out;
`endif
    logic        busy;
    logic        done;
    logic        range_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cordic_vectoring_four_loop dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
`ifdef CORDIC_VEC_MAG_EN
        .mag_out   (mag_out),
`endif
        .busy      (busy),
        .done      (done),
        .range_err (range_err)
    );

    function automatic int sx(input logic [21:0] v);
        return int'($signed(v));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_angle(input int x, input int y);
        if (x < 0 || (x == 0 && y == 0)) return 0;
        return int'($atan2($itor(y), $itor(x)) * 1048576.0 / 1048576.0);
    endfunction

    function automatic int ref_mag(input int x, input int y);
        if (x < 0) return 0;
        return int'($sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y)));
    endfunction

    function automatic int ref_angle_q(input int x, input int y);
        if (x < 0 || (x == 0 && y == 0)) return 0;
        return int'($atan2($itor(y), $itor(x)) * 1048576.0);
    endfunction

    // Start one operation and wait for done; inputs are scrambled after capture
    task automatic do_op(input logic [21:0] x, input logic [21:0] y, output int lat);
        @(negedge clk);
        x_in   = x;
        y_in   = y;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            clk_en = 1'b0;
            x_in   = 22'($urandom);
            y_in   = 22'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: done not seen within 20 cycles (x=%h y=%h)", x, y);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        clk_en = 1'b0;
        x_in   = '0;
        y_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({done, busy, range_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: done/busy/range_err=%b required 000", {done, busy, range_err});
        end
        n_vec++;
        if (angle_out !== 22'h0) begin
            n_err++;
            $display("FAIL reset_angle: got %h required 000000", angle_out);
        end
`ifdef CORDIC_VEC_MAG_EN
        n_vec++;
        if (mag_out !== 22'h0) begin
            n_err++;
            $display("FAIL reset_mag: got %h required 000000", mag_out);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency;
        int lat;
        logic [21:0] held;
        do_op(22'h080000, 22'h000000, lat);
        n_vec++;
        if (lat !== LAT) begin
            n_err++;
            $display("FAIL latency: got %0d cycles required %0d", lat, LAT);
        end
        n_vec++;
        if (busy !== 1'b0 || range_err !== 1'b0) begin
            n_err++;
            $display("FAIL done_flags: busy=%b range_err=%b required 0 0", busy, range_err);
        end
        n_vec++;
        if (iabs(sx(angle_out)) > TOL_DIR) begin
            n_err++;
            $display("FAIL angle_x_axis: got %h required 000000 +/-40", angle_out);
        end
`ifdef CORDIC_VEC_MAG_EN
        n_vec++;
        if (iabs(sx(mag_out) - 'h080000) > TOL_DIR) begin
            n_err++;
            $display("FAIL mag_x_axis: got %h required 080000 +/-40", mag_out);
        end
`endif
        held = angle_out;
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: done=%b one cycle later, required 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (angle_out !== held) begin
            n_err++;
            $display("FAIL hold: angle_out %h changed, required %h", angle_out, held);
        end
    endtask

    task automatic test_directed;
        logic [21:0] tx   [3] = '{22'h080000, 22'h080000, 22'h000000};
        logic [21:0] ty   [3] = '{22'h080000, 22'h380000, 22'h080000};
        int          ta   [3] = '{'h0C90FD, -'h0C90FD, 'h1921FB};
        int          tm   [3] = '{'h0B504F, 'h0B504F, 'h080000};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(tx[i], ty[i], lat);
            n_vec++;
            if (iabs(sx(angle_out) - ta[i]) > TOL_DIR || range_err !== 1'b0) begin
                n_err++;
                $display("FAIL directed_angle[%0d]: got %h rerr=%b required %h +/-40 rerr=0",
                         i, angle_out, range_err, 22'(ta[i]));
            end
`ifdef CORDIC_VEC_MAG_EN
            n_vec++;
            if (iabs(sx(mag_out) - tm[i]) > TOL_DIR) begin
                n_err++;
                $display("FAIL directed_mag[%0d]: got %h required %h +/-40", i, mag_out, 22'(tm[i]));
            end
`else
            if (tm[i] < 0) $display("unexpected table entry");
`endif
        end
    endtask

    task automatic test_boundaries;
        int lat;
        do_op(22'h380000, 22'h010000, lat);
        n_vec++;
        if (lat !== LAT || range_err !== 1'b1 || angle_out !== 22'h0) begin
            n_err++;
            $display("FAIL neg_x: lat=%0d rerr=%b angle=%h required lat=%0d rerr=1 angle=000000",
                     lat, range_err, angle_out, LAT);
        end
`ifdef CORDIC_VEC_MAG_EN
        n_vec++;
        if (mag_out !== 22'h0) begin
            n_err++;
            $display("FAIL neg_x_mag: got %h required 000000", mag_out);
        end
`endif
        do_op(22'h000000, 22'h000000, lat);
        n_vec++;
        if (range_err !== 1'b0 || angle_out !== 22'h0) begin
            n_err++;
            $display("FAIL origin: rerr=%b angle=%h required rerr=0 angle=000000", range_err, angle_out);
        end
`ifdef CORDIC_VEC_MAG_EN
        n_vec++;
        if (mag_out !== 22'h0) begin
            n_err++;
            $display("FAIL origin_mag: got %h required 000000", mag_out);
        end
`endif
    endtask

    task automatic test_random;
        int lat, x, y, ea, em;
        for (int n = 0; n < 14; n++) begin
            x = int'($urandom_range(32'h040000, 32'h0C0000));
            if (n % 5 == 4) x = -x;
            y = int'($urandom_range(0, 32'h180000)) - 'h0C0000;
            ea = ref_angle_q(x, y);
            em = ref_mag(x, y);
            do_op(22'(x), 22'(y), lat);
            n_vec++;
            if (iabs(sx(angle_out) - ea) > TOL_RND || range_err !== (x < 0)) begin
                n_err++;
                $display("FAIL random_angle[%0d]: x=%h y=%h got %h rerr=%b required %h +/-60 rerr=%b",
                         n, 22'(x), 22'(y), angle_out, range_err, 22'(ea), (x < 0));
            end
`ifdef CORDIC_VEC_MAG_EN
            n_vec++;
            if (iabs(sx(mag_out) - em) > TOL_RND) begin
                n_err++;
                $display("FAIL random_mag[%0d]: got %h required %h +/-60", n, mag_out, 22'(em));
            end
`else
            if (em < 0 || ref_angle(x, y) > 2) $display("unexpected reference value");
`endif
        end
    endtask

    task automatic test_reset_midflight;
        int dones = 0;
        @(negedge clk);
        x_in   = 22'h080000;
        y_in   = 22'h080000;
        clk_en = 1'b1;
        @(posedge clk);                 // edge N
        @(negedge clk);
        clk_en = 1'b0;
        @(posedge clk);                 // edge N+1
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);                 // edge N+2
        #1;
        n_vec++;
        if ({done, busy, range_err} !== 3'b000 || angle_out !== 22'h0) begin
            n_err++;
            $display("FAIL midflight_reset: done/busy/rerr=%b angle=%h required 000 000000",
                     {done, busy, range_err}, angle_out);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL midflight_no_done: got %0d dones required 0", dones);
        end
    endtask

    task automatic test_held_enable;
        int dones = 0;
        int dlat  = 0;
        logic [21:0] ang = '0;
        @(negedge clk);
        x_in   = 22'h080000;
        y_in   = 22'h380000;
        clk_en = 1'b1;
        @(posedge clk);                 // edge N
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                dlat = c;
                ang  = angle_out;
            end
            @(negedge clk);
            if (c >= LAT) clk_en = 1'b0;
        end
        n_vec++;
        if (dones !== 1 || dlat !== LAT) begin
            n_err++;
            $display("FAIL held_enable: got %0d dones at cycle %0d required 1 at %0d", dones, dlat, LAT);
        end
        n_vec++;
        if (iabs(sx(ang) + 'h0C90FD) > TOL_DIR) begin
            n_err++;
            $display("FAIL held_enable_angle: got %h required 336F03 +/-40", ang);
        end
    endtask

    task automatic test_back_to_back;
        int lat1, lat2;
        do_op(22'h080000, 22'h000000, lat1);
        do_op(22'h000000, 22'h080000, lat2);
        n_vec++;
        if (lat1 !== LAT || lat2 !== LAT) begin
            n_err++;
            $display("FAIL back_to_back_latency: got %0d,%0d required %0d,%0d", lat1, lat2, LAT, LAT);
        end
        n_vec++;
        if (iabs(sx(angle_out) - 'h1921FB) > TOL_DIR) begin
            n_err++;
            $display("FAIL back_to_back_angle: got %h required 1921FB +/-40", angle_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_latency;
        test_directed;
        test_boundaries;
        test_random;
        test_reset_midflight;
        test_held_enable;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
